// File: rtl/alu_reg_seq.sv
// Sequencer that buffers register-register ALU instructions and
// steps each one through an EXEC cycle and a WB cycle on the datapath.
module alu_reg_seq #(
  parameter bit OVF_NOWRITE = 1'b1
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Inst_Valid,
  output logic       Inst_Ready,
  input  logic [2:0] Inst_Op,
  input  logic [4:0] Inst_RA,
  input  logic [4:0] Inst_RB,
  input  logic [4:0] Inst_RW,
  output logic [4:0] R_Addr_A,
  output logic [4:0] R_Addr_B,
  output logic [4:0] W_Addr,
  output logic       Write_Reg,
  output logic [2:0] ALU_OP,
  input  logic       ZF,
  input  logic       OF,
  output logic       Done,
  output logic       Flag_Z,
  output logic       Flag_O,
  output logic       Busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_t;

  state_t      r_state;
  logic [17:0] r_mem [2];
  logic        r_wptr;
  logic        r_rptr;
  logic [1:0]  r_cnt;
  logic [2:0]  r_op;
  logic [4:0]  r_ra;
  logic [4:0]  r_rb;
  logic [4:0]  r_rw;
  logic        r_wr;
  logic        r_done;
  logic        r_zs;
  logic        r_os;
  logic        r_fz;
  logic        r_fo;

  logic        w_full;
  logic        w_empty;
  logic        w_push;
  logic        w_pop;
  logic [17:0] w_head;

  assign w_full  = (r_cnt == 2'd2);
  assign w_empty = (r_cnt == 2'd0);
  assign w_push  = Inst_Valid && Inst_Ready;
  // Only IDLE and WB hand off to EXEC; a push this edge is not visible yet.
  assign w_pop   = !w_empty && (r_state == IDLE || r_state == WB);
  assign w_head  = r_mem[r_rptr];

  assign Inst_Ready = !Reset && !w_full;
  assign Busy       = (r_state != IDLE) || !w_empty;
  assign R_Addr_A   = r_ra;
  assign R_Addr_B   = r_rb;
  assign W_Addr     = r_rw;
  assign ALU_OP     = r_op;
  assign Write_Reg  = r_wr;
  assign Done       = r_done;
  assign Flag_Z     = r_fz;
  assign Flag_O     = r_fo;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wptr   <= 1'b0;
      r_rptr   <= 1'b0;
      r_cnt    <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= {Inst_Op, Inst_RA, Inst_RB, Inst_RW};
        r_wptr        <= ~r_wptr;
      end
      if (w_pop) begin
        r_rptr <= ~r_rptr;
      end
      unique case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 2'd1;
        2'b01:   r_cnt <= r_cnt - 2'd1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state <= IDLE;
      r_op    <= '0;
      r_ra    <= '0;
      r_rb    <= '0;
      r_rw    <= '0;
      r_wr    <= 1'b0;
      r_done  <= 1'b0;
      r_zs    <= 1'b0;
      r_os    <= 1'b0;
      r_fz    <= 1'b0;
      r_fo    <= 1'b0;
    end else begin
      r_wr   <= 1'b0;
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_pop) begin
            {r_op, r_ra, r_rb, r_rw} <= w_head;
            r_state <= EXEC;
          end
        end
        EXEC: begin
          r_zs    <= ZF;
          r_os    <= OF;
          r_wr    <= (r_rw != 5'd0) && !(OVF_NOWRITE && OF);
          r_done  <= 1'b1;
          r_state <= WB;
        end
        WB: begin
          r_fz <= r_zs;
          r_fo <= r_os;
          if (w_pop) begin
            {r_op, r_ra, r_rb, r_rw} <= w_head;
            r_state <= EXEC;
          end else begin
            {r_op, r_ra, r_rb, r_rw} <= '0;
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_reg_seq.sv
// Scoreboard bench for alu_reg_seq with a behavioural register file
// and ALU; a second instance runs with overflow writeback enabled.
module tb_alu_reg_seq;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       Inst_Valid;
  logic [2:0] Inst_Op;
  logic [4:0] Inst_RA, Inst_RB, Inst_RW;

  logic       Inst_Ready, Write_Reg, ZF, OF, Done, Flag_Z, Flag_O, Busy;
  logic [4:0] R_Addr_A, R_Addr_B, W_Addr;
  logic [2:0] ALU_OP;

  logic       d0_ready, d0_wr, d0_zf, d0_of, d0_done, d0_fz, d0_fo, d0_busy;
  logic [4:0] d0_ra, d0_rb, d0_wa;
  logic [2:0] d0_op;

  always #5 Clk = ~Clk;

  alu_reg_seq dut (
    .Clk(Clk), .Reset(Reset), .Inst_Valid(Inst_Valid),
    .Inst_Ready(Inst_Ready), .Inst_Op(Inst_Op), .Inst_RA(Inst_RA),
    .Inst_RB(Inst_RB), .Inst_RW(Inst_RW), .R_Addr_A(R_Addr_A),
    .R_Addr_B(R_Addr_B), .W_Addr(W_Addr), .Write_Reg(Write_Reg),
    .ALU_OP(ALU_OP), .ZF(ZF), .OF(OF), .Done(Done), .Flag_Z(Flag_Z),
    .Flag_O(Flag_O), .Busy(Busy)
  );

  alu_reg_seq #(.OVF_NOWRITE(1'b0)) dut0 (
    .Clk(Clk), .Reset(Reset), .Inst_Valid(Inst_Valid),
    .Inst_Ready(d0_ready), .Inst_Op(Inst_Op), .Inst_RA(Inst_RA),
    .Inst_RB(Inst_RB), .Inst_RW(Inst_RW), .R_Addr_A(d0_ra),
    .R_Addr_B(d0_rb), .W_Addr(d0_wa), .Write_Reg(d0_wr),
    .ALU_OP(d0_op), .ZF(d0_zf), .OF(d0_of), .Done(d0_done),
    .Flag_Z(d0_fz), .Flag_O(d0_fo), .Busy(d0_busy)
  );

  // Datapath model: 010 add, 110 sub, 000 and, 001 or.
  function automatic logic [33:0] alu(logic [2:0] op, logic [31:0] a, logic [31:0] b);
    logic [31:0] r;
    logic        o;
    r = '0;
    o = 1'b0;
    case (op)
      3'b010: begin r = a + b; o = (a[31] == b[31]) && (r[31] != a[31]); end
      3'b110: begin r = a - b; o = (a[31] != b[31]) && (r[31] != a[31]); end
      3'b000: r = a & b;
      3'b001: r = a | b;
      default: r = '0;
    endcase
    return {o, (r == 32'd0), r};
  endfunction

  function automatic logic [31:0] init_val(int i);
    case (i)
      1:  return 32'd5;
      2:  return 32'd7;
      4:  return 32'h55;
      5:  return 32'h1234;
      11: return 32'h7FFF_FFFF;
      12: return 32'd1;
      default: return 32'd0;
    endcase
  endfunction

  logic [31:0] rf  [32];
  logic [31:0] rf0 [32];
  logic [33:0] alu_o, alu0_o;

  always_comb begin
    alu_o  = alu(ALU_OP, rf[R_Addr_A], rf[R_Addr_B]);
    alu0_o = alu(d0_op, rf0[d0_ra], rf0[d0_rb]);
  end
  assign OF    = alu_o[33];
  assign ZF    = alu_o[32];
  assign d0_of = alu0_o[33];
  assign d0_zf = alu0_o[32];

  always @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < 32; i++) begin
        rf[i]  <= init_val(i);
        rf0[i] <= init_val(i);
      end
    end else begin
      if (Write_Reg) rf[W_Addr] <= alu_o[31:0];
      if (d0_wr) rf0[d0_wa] <= alu0_o[31:0];
    end
  end

  typedef struct {
    logic [4:0]  rw;
    logic [31:0] val;
    logic        wr;
    logic        z;
    logic        o;
  } exp_t;

  exp_t sb[$];
  int   done_t[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;
  bit   sb_off = 1'b0;
  bit   saw_full = 1'b0;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(logic [2:0] op, logic [4:0] ra, logic [4:0] rb,
                      logic [4:0] rw, logic [31:0] val, logic wr,
                      logic z, logic o);
    int w;
    Inst_Valid = 1'b1;
    Inst_Op = op;
    Inst_RA = ra;
    Inst_RB = rb;
    Inst_RW = rw;
    w = 0;
    while (!Inst_Ready && w < 20) begin
      saw_full = 1'b1;
      @(negedge Clk);
      w++;
    end
    if (w >= 20) chk("push_timeout", {31'd0, Inst_Ready}, 32'd1);
    @(posedge Clk);
    if (!sb_off) sb.push_back('{rw: rw, val: val, wr: wr, z: z, o: o});
    @(negedge Clk);
  endtask

  task automatic idle();
    Inst_Valid = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while ((sb.size() != 0 || Busy) && w < 60) begin
      @(negedge Clk);
      w++;
    end
    chk("drain", sb.size() + {31'd0, Busy}, 32'd0);
    @(negedge Clk);
  endtask

  // Monitor: pops one expectation per Done pulse.
  initial begin
    exp_t e;
    forever begin
      @(negedge Clk);
      if (Done && !sb_off) begin
        if (sb.size() == 0) begin
          chk("sb_underflow", sb.size(), 32'd1);
        end else begin
          e = sb.pop_front();
          done_t.push_back(cyc);
          chk("write_reg", {31'd0, Write_Reg}, {31'd0, e.wr});
          chk("w_addr", {27'd0, W_Addr}, {27'd0, e.rw});
          @(negedge Clk);
          chk("flag_z", {31'd0, Flag_Z}, {31'd0, e.z});
          chk("flag_o", {31'd0, Flag_O}, {31'd0, e.o});
          chk("rf_value", rf[e.rw], e.val);
        end
      end
    end
  end

  initial begin
    int lat, base, nd;
    Reset = 1'b1;
    Inst_Valid = 1'b0;
    Inst_Op = '0;
    Inst_RA = '0;
    Inst_RB = '0;
    Inst_RW = '0;
    repeat (3) @(negedge Clk);
    chk("rst_ready", {31'd0, Inst_Ready}, 32'd0);
    chk("rst_busy", {31'd0, Busy}, 32'd0);
    chk("rst_outs", {Done, Write_Reg, Flag_Z, Flag_O, ALU_OP, R_Addr_A, R_Addr_B, W_Addr}, 32'd0);
    Reset = 1'b0;
    #1;
    chk("ready_after_rst", {31'd0, Inst_Ready}, 32'd1);
    @(negedge Clk);

    // Single op: R3 = 5 + 7
    push(3'b010, 5'd1, 5'd2, 5'd3, 32'd12, 1'b1, 1'b0, 1'b0);
    idle();
    lat = 1;
    while (!Done && lat < 8) begin
      @(negedge Clk);
      lat++;
    end
    chk("latency", lat, 32'd3);
    drain();

    // Back-to-back burst of four
    base = done_t.size();
    saw_full = 1'b0;
    push(3'b010, 5'd1, 5'd2, 5'd7, 32'd12, 1'b1, 1'b0, 1'b0);
    push(3'b110, 5'd2, 5'd1, 5'd8, 32'd2, 1'b1, 1'b0, 1'b0);
    push(3'b000, 5'd1, 5'd2, 5'd9, 32'd5, 1'b1, 1'b0, 1'b0);
    push(3'b001, 5'd1, 5'd2, 5'd10, 32'd7, 1'b1, 1'b0, 1'b0);
    idle();
    drain();
    chk("b2b_full_seen", {31'd0, saw_full}, 32'd1);
    chk("b2b_done_cnt", done_t.size() - base, 32'd4);
    if (done_t.size() - base == 4) begin
      for (int i = base + 1; i < base + 4; i++)
        chk("b2b_done_gap", done_t[i] - done_t[i-1], 32'd2);
    end

    // Overflow: R4 keeps 0x55, Flag_O set
    push(3'b010, 5'd11, 5'd12, 5'd4, 32'h55, 1'b0, 1'b0, 1'b1);
    idle();
    drain();
    chk("ovf_allowed_rf0", rf0[4], 32'h8000_0000);
    chk("ovf_allowed_fo", {31'd0, d0_fo}, 32'd1);

    // Zero flag: R6 = R5 - R5
    push(3'b110, 5'd5, 5'd5, 5'd6, 32'd0, 1'b1, 1'b1, 1'b0);
    idle();
    drain();

    // Zero destination: no write, flags still update
    push(3'b010, 5'd11, 5'd12, 5'd0, 32'd0, 1'b0, 1'b0, 1'b1);
    idle();
    drain();
    chk("rf0_r3", rf0[3], 32'd12);

    // Reset in WB with two entries buffered
    sb_off = 1'b1;
    push(3'b010, 5'd1, 5'd2, 5'd13, 32'd12, 1'b1, 1'b0, 1'b0);
    push(3'b010, 5'd1, 5'd2, 5'd14, 32'd12, 1'b1, 1'b0, 1'b0);
    push(3'b010, 5'd1, 5'd2, 5'd15, 32'd12, 1'b1, 1'b0, 1'b0);
    idle();
    chk("wb_done", {31'd0, Done}, 32'd1);
    chk("wb_write", {31'd0, Write_Reg}, 32'd1);
    chk("wb_full", {31'd0, Inst_Ready}, 32'd0);
    #2;
    Reset = 1'b1;
    #1;
    chk("async_wr_drop", {31'd0, Write_Reg}, 32'd0);
    chk("async_busy", {31'd0, Busy}, 32'd0);
    repeat (3) @(negedge Clk);
    Reset = 1'b0;
    #1;
    chk("rel_ready", {31'd0, Inst_Ready}, 32'd1);
    chk("rel_busy", {31'd0, Busy}, 32'd0);
    nd = 0;
    repeat (10) begin
      @(negedge Clk);
      if (Done) nd++;
    end
    chk("no_stray_done", nd, 32'd0);
    chk("idle_outs", {ALU_OP, R_Addr_A, R_Addr_B, W_Addr, Write_Reg}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
